// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM read port
// among NUM_REQ burst requesters, with id/last-tagged pixel return.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 24,
    parameter int LEN_W   = 10,
    parameter int ROM_LAT = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      rom_rd,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic                      rd_last,
    output logic [DATA_W-1:0]         rd_data
);
    localparam logic IDLE  = 1'b0;
    localparam logic BURST = 1'b1;
    localparam int   TW    = ID_W + 2;
    localparam int   SRW   = ROM_LAT * TW;

    logic              state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   idx;
    logic              win_vld;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remain;
    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [LEN_W-1:0]  len_a  [NUM_REQ];
    logic [SRW-1:0]    sr;
    logic [TW-1:0]     tag_in;
    logic [TW-1:0]     tag_out;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
            len_a[i]  = req_len[i*LEN_W +: LEN_W];
        end
    end

    // First set request scanning cyclically upward from ptr.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cur_id   <= '0;
            cur_addr <= '0;
            remain   <= '0;
            gnt      <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (gnt == '0 && win_vld) begin
                        gnt      <= NUM_REQ'(1) << win_id;
                        cur_addr <= addr_a[win_id];
                        remain   <= len_a[win_id];
                        cur_id   <= win_id;
                        ptr      <= (win_id == ID_W'(NUM_REQ - 1))
                                    ? '0 : win_id + ID_W'(1);
                        if (len_a[win_id] != '0)
                            state <= BURST;
                    end
                end
                BURST: begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                    remain   <= remain - LEN_W'(1);
                    if (remain == LEN_W'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == BURST);
    assign rom_rd   = busy;
    assign rom_addr = cur_addr;

    // Tags travel alongside the ROM pipeline so they line up with rom_data.
    assign tag_in = {rom_rd, rom_rd && (remain == LEN_W'(1)), cur_id};

    always_ff @(posedge Clk) begin
        if (Reset)
            sr <= '0;
        else
            sr <= (sr << TW) | SRW'(tag_in);
    end

    assign tag_out  = sr[SRW-1 -: TW];
    assign rd_valid = tag_out[TW-1];
    assign rd_last  = tag_out[TW-2];
    assign rd_id    = tag_out[ID_W-1:0];
    assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: random and directed bursts checked against a
// cycle-scheduled transaction model of the arbiter timing rules.
module tb_sprite_rom_arbiter;
    localparam int NR   = 4;
    localparam int AW   = 20;
    localparam int DW   = 24;
    localparam int LW   = 10;
    localparam int RL   = 2;
    localparam int IW   = 2;
    localparam int MAXC = 6000;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]    gnt;
    logic             busy;
    logic             rom_rd;
    logic [AW-1:0]    rom_addr;
    logic [DW-1:0]    rom_data;
    logic             rd_valid;
    logic [IW-1:0]    rd_id;
    logic             rd_last;
    logic [DW-1:0]    rd_data;

    sprite_rom_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW),
        .LEN_W(LW), .ROM_LAT(RL), .ID_W(IW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .req(req),
        .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .busy(busy), .rom_rd(rom_rd),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_valid(rd_valid), .rd_id(rd_id),
        .rd_last(rd_last), .rd_data(rd_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return {a[3:0], a} ^ 24'h5A3C96;
    endfunction

    // Behavioural ROM with RL cycles of read latency.
    logic [AW-1:0] rpipe [RL];
    always @(posedge Clk) begin
        rpipe[0] <= rom_addr;
        for (int i = 1; i < RL; i++)
            rpipe[i] <= rpipe[i-1];
    end
    assign rom_data = pix(rpipe[RL-1]);

    bit [NR-1:0] e_gnt   [MAXC];
    bit          e_busy  [MAXC];
    bit          e_rd    [MAXC];
    bit [AW-1:0] e_addr  [MAXC];
    bit          e_vld   [MAXC];
    int          e_id    [MAXC];
    bit          e_last  [MAXC];
    bit [AW-1:0] e_vaddr [MAXC];

    int          cyc;
    int          free_at;
    int          mptr;
    bit          pend    [NR];
    int          drop_at [NR];
    bit [AW-1:0] paddr   [NR];
    int          plen    [NR];
    int          gq      [$];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic raise(input int i, input bit [AW-1:0] a,
                         input int len);
        pend[i]    = 1'b1;
        paddr[i]   = a;
        plen[i]    = len;
        drop_at[i] = -1;
    endtask

    // Winner takes the next ROM slot; every effect lands on a known cycle.
    task automatic schedule();
        int w;
        int t;
        w = -1;
        t = cyc;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (mptr + k) % NR;
            if (w < 0 && req[i]) w = i;
        end
        e_gnt[t+1][w] = 1'b1;
        mptr          = (w + 1) % NR;
        drop_at[w]    = t + 2;
        for (int k = 0; k < plen[w]; k++) begin
            bit [AW-1:0] a;
            a = paddr[w] + AW'(k);
            e_rd[t+1+k]     = 1'b1;
            e_busy[t+1+k]   = 1'b1;
            e_addr[t+1+k]   = a;
            e_vld[t+1+k+RL] = 1'b1;
            e_id[t+1+k+RL]  = w;
            e_vaddr[t+1+k+RL] = a;
            e_last[t+1+k+RL]  = (k == plen[w] - 1);
        end
        free_at = (plen[w] == 0) ? t + 2 : t + plen[w] + 1;
    endtask

    task automatic model_reset();
        for (int c = cyc + 1; c < MAXC; c++) begin
            e_gnt[c]  = '0;
            e_busy[c] = 1'b0;
            e_rd[c]   = 1'b0;
            e_vld[c]  = 1'b0;
            e_last[c] = 1'b0;
        end
        mptr    = 0;
        free_at = cyc + 1;
    endtask

    task automatic compare();
        int c;
        c = cyc;
        chk("gnt", gnt, e_gnt[c]);
        chk("busy", busy, e_busy[c]);
        chk("rom_rd", rom_rd, e_rd[c]);
        if (e_rd[c])
            chk("rom_addr", rom_addr, e_addr[c]);
        chk("rd_valid", rd_valid, e_vld[c]);
        if (e_vld[c]) begin
            chk("rd_id", rd_id, e_id[c]);
            chk("rd_last", rd_last, e_last[c]);
            chk("rd_data", rd_data, pix(e_vaddr[c]));
        end
        for (int i = 0; i < NR; i++)
            if (gnt[i] === 1'b1) gq.push_back(i);
    endtask

    task automatic step(input bit rst);
        @(posedge Clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++)
            if (pend[i] && drop_at[i] == cyc) begin
                pend[i]    = 1'b0;
                drop_at[i] = -1;
            end
        Reset = rst;
        for (int i = 0; i < NR; i++) begin
            req[i] = pend[i];
            req_addr[i*AW +: AW] = pend[i] ? paddr[i] : AW'($urandom);
            req_len[i*LW +: LW]  = pend[i] ? LW'(plen[i]) : LW'($urandom);
        end
        if (rst)
            model_reset();
        else if (cyc >= free_at && req != '0)
            schedule();
        @(negedge Clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int s = 0; s < n; s++) step(1'b0);
    endtask

    initial begin
        Reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        cyc      = 0;
        free_at  = 0;
        mptr     = 0;
        n_chk    = 0;
        n_fail   = 0;
        for (int i = 0; i < NR; i++) begin
            pend[i]    = 1'b0;
            drop_at[i] = -1;
        end

        repeat (3) step(1'b1);
        chk("rst_rom_addr", rom_addr, 0);

        gq.delete();
        for (int i = 0; i < NR; i++)
            raise(i, AW'(32'h1000 + i * 16), 1);
        for (int s = 0; s < 40 && gq.size() < 5; s++) begin
            step(1'b0);
            for (int i = 0; i < NR; i++)
                if (!pend[i]) raise(i, AW'(32'h1000 + i * 16), 1);
        end
        idle(20);
        for (int k = 0; k < 5; k++)
            chk($sformatf("fair%0d", k), gq[k], k % NR);

        raise(0, 20'h00100, 3);
        idle(15);

        raise(2, 20'h02000, 2);
        idle(10);
        gq.delete();
        raise(0, 20'h00300, 1);
        raise(2, 20'h00400, 1);
        idle(12);
        chk("ptr_win0", gq[0], 0);
        chk("ptr_win1", gq[1], 2);

        raise(1, 20'hFFFFE, 4);
        idle(12);

        gq.delete();
        raise(1, 20'h00500, 0);
        idle(6);
        raise(3, 20'h00600, 2);
        idle(10);
        chk("len0_gnt", gq[0], 1);
        chk("len0_next", gq[1], 3);

        for (int s = 0; s < 2500; s++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    bit [AW-1:0] a;
                    int          l;
                    a = ($urandom_range(0, 7) == 0)
                        ? AW'(20'hFFFF0 + $urandom_range(0, 15))
                        : AW'($urandom);
                    l = ($urandom_range(0, 9) == 0)
                        ? $urandom_range(0, 30)
                        : $urandom_range(0, 6);
                    raise(i, a, l);
                end
            step(1'b0);
        end
        idle(60);

        gq.delete();
        raise(2, 20'h00700, 8);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        idle(6);
        raise(0, 20'h00800, 2);
        raise(3, 20'h00900, 2);
        idle(15);
        chk("rst_gnt2", gq[0], 2);
        chk("rst_ptr0", gq[1], 0);
        chk("rst_then3", gq[2], 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
